// File: rtl/MD_pkg.sv
// Shared widths and the injector state type for the molecular-dynamics position ring.
package MD_pkg;

    localparam int CACHE_ADDR_WIDTH        = 4;
    localparam int PARTICLE_ID_WIDTH       = CACHE_ADDR_WIDTH + 1;
    localparam int GLOBAL_CELL_ID_WIDTH    = 3;
    localparam int NODE_ID_WIDTH           = 3;
    localparam int NB_CELL_COUNT_WIDTH     = 3;
    localparam int NUM_REMOTE_DEST_NODES   = 3;
    localparam int OFFSET_PKT_STRUCT_WIDTH = 32;
    localparam int GCID_WIDTH              = 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int SPLIT_WIDTH             = (NUM_REMOTE_DEST_NODES + 1) * NB_CELL_COUNT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        PRESENT,
        DONE
    } inj_state_t;

endpackage

// File: rtl/pos_ring_injector_if.sv
// Cache read port plus the local-injection bundle toward the attached ring node.
interface pos_ring_injector_if;
    import MD_pkg::*;

    logic                               o_cache_rd_en;
    logic [CACHE_ADDR_WIDTH-1:0]        o_cache_rd_addr;
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_cache_rd_data;
    logic                               i_dispatcher_back_pressure;
    logic                               i_dirty_feedback;
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] o_local_offset_pkt;
    logic [GCID_WIDTH-1:0]              o_local_gcid;
    logic [NODE_ID_WIDTH-1:0]           o_local_node_id;
    logic [SPLIT_WIDTH-1:0]             o_local_split_lifetime;
    logic                               o_local_valid;
    logic                               o_local_dirty;

    modport master (
        output o_cache_rd_en, o_cache_rd_addr,
        input  i_cache_rd_data, i_dispatcher_back_pressure, i_dirty_feedback,
        output o_local_offset_pkt, o_local_gcid, o_local_node_id,
        output o_local_split_lifetime, o_local_valid, o_local_dirty
    );

    modport slave (
        input  o_cache_rd_en, o_cache_rd_addr,
        output i_cache_rd_data, i_dispatcher_back_pressure, i_dirty_feedback,
        input  o_local_offset_pkt, o_local_gcid, o_local_node_id,
        input  o_local_split_lifetime, o_local_valid, o_local_dirty
    );

endinterface

// File: rtl/pos_ring_injector.sv
// Walks one cell's position cache and offers each offset packet to the ring node,
// holding it until the node reports consumption through dirty feedback.
module pos_ring_injector
    import MD_pkg::*;
#(
    parameter int CACHE_RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [PARTICLE_ID_WIDTH-1:0] i_num_particles,
    input  logic [GCID_WIDTH-1:0]        i_gcid,
    input  logic [NODE_ID_WIDTH-1:0]     i_node_id,
    input  logic [SPLIT_WIDTH-1:0]       i_split_lifetime,
    pos_ring_injector_if.master          ring,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam logic [CACHE_ADDR_WIDTH-1:0]  ADDR_ONE  = 1;
    localparam logic [PARTICLE_ID_WIDTH-1:0] COUNT_ONE = 1;

    // The READ -> CAPTURE timing assumes the cache answers exactly one cycle later.
    if (CACHE_RD_LATENCY != 1) begin : g_latency_check
        $error("pos_ring_injector supports only CACHE_RD_LATENCY = 1");
    end

    inj_state_t                         state;
    inj_state_t                         state_next;
    logic [CACHE_ADDR_WIDTH-1:0]        addr_q;
    logic [PARTICLE_ID_WIDTH-1:0]       count_q;
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] pkt_q;
    logic [GCID_WIDTH-1:0]              gcid_q;
    logic [NODE_ID_WIDTH-1:0]           node_id_q;
    logic [SPLIT_WIDTH-1:0]             split_q;
    logic                               consumed;
    logic                               last_particle;

    // Back pressure masks feedback, so a packet only retires when the node can really take it.
    assign consumed      = (state == PRESENT) && ring.i_dirty_feedback && !ring.i_dispatcher_back_pressure;
    assign last_particle = ({1'b0, addr_q} == (count_q - COUNT_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            count_q   <= '0;
            pkt_q     <= '0;
            gcid_q    <= '0;
            node_id_q <= '0;
            split_q   <= '0;
        end else begin
            if ((state == IDLE) && i_start && (i_num_particles != '0)) begin
                addr_q    <= '0;
                count_q   <= i_num_particles;
                gcid_q    <= i_gcid;
                node_id_q <= i_node_id;
                split_q   <= i_split_lifetime;
            end
            if (state == CAPTURE) begin
                pkt_q <= ring.i_cache_rd_data;
            end
            if (consumed && !last_particle) begin
                addr_q <= addr_q + ADDR_ONE;
            end
        end
    end

    always_comb begin
        state_next         = state;
        ring.o_cache_rd_en = 1'b0;
        ring.o_local_valid = 1'b0;
        ring.o_local_dirty = 1'b0;
        o_busy             = 1'b0;
        o_done             = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = (i_num_particles == '0) ? DONE : READ;
                end
            end
            READ: begin
                ring.o_cache_rd_en = 1'b1;
                o_busy             = 1'b1;
                state_next         = CAPTURE;
            end
            CAPTURE: begin
                o_busy     = 1'b1;
                state_next = PRESENT;
            end
            PRESENT: begin
                o_busy             = 1'b1;
                ring.o_local_dirty = 1'b1;
                ring.o_local_valid = !ring.i_dispatcher_back_pressure;
                if (consumed) begin
                    state_next = last_particle ? DONE : READ;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ring.o_cache_rd_addr        = addr_q;
    assign ring.o_local_offset_pkt     = pkt_q;
    assign ring.o_local_gcid           = gcid_q;
    assign ring.o_local_node_id        = node_id_q;
    assign ring.o_local_split_lifetime = split_q;

endmodule

// File: tb/tb_pos_ring_injector.sv
// Directed bench for pos_ring_injector: a timeline model of each sweep is compared every
// cycle, and a few literal expectations at known cycles pin that model down.
module tb_pos_ring_injector;
    import MD_pkg::*;

    localparam int CACHE_DEPTH = 1 << CACHE_ADDR_WIDTH;

    logic                         clk   = 1'b0;
    logic                         rst   = 1'b1;
    logic                         start = 1'b0;
    logic [PARTICLE_ID_WIDTH-1:0] num   = '0;
    logic [GCID_WIDTH-1:0]        gcid  = '0;
    logic [NODE_ID_WIDTH-1:0]     node  = '0;
    logic [SPLIT_WIDTH-1:0]       split = '0;
    logic                         busy;
    logic                         done;

    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] mem [0:CACHE_DEPTH-1];

    int n_cmp  = 0;
    int n_fail = 0;
    int cur_cycle = 0;

    pos_ring_injector_if ring_bus();

    pos_ring_injector #(.CACHE_RD_LATENCY(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (start),
        .i_num_particles  (num),
        .i_gcid           (gcid),
        .i_node_id        (node),
        .i_split_lifetime (split),
        .ring             (ring_bus),
        .o_busy           (busy),
        .o_done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ring_bus.o_cache_rd_en) begin
            ring_bus.i_cache_rd_data <= mem[ring_bus.o_cache_rd_addr];
        end
    end

    // Model: m_age is how long the current fetch has been under way (1 = address issued,
    // 2 = data returning, 3 = packet on offer); 0 means no sweep is running.
    int                                 m_age   = 0;
    int                                 m_idx   = 0;
    int                                 m_count = 0;
    bit                                 m_done  = 1'b0;
    bit                                 m_init  = 1'b0;
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] m_pkt   = '0;
    logic [GCID_WIDTH-1:0]              m_gcid  = '0;
    logic [NODE_ID_WIDTH-1:0]           m_node  = '0;
    logic [SPLIT_WIDTH-1:0]             m_split = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_age   <= 0;
            m_idx   <= 0;
            m_count <= 0;
            m_done  <= 1'b0;
            m_pkt   <= '0;
            m_gcid  <= '0;
            m_node  <= '0;
            m_split <= '0;
            m_init  <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_age == 0) begin
                if (!m_done && start) begin
                    if (num == '0) begin
                        m_done <= 1'b1;
                    end else begin
                        m_count <= int'(num);
                        m_idx   <= 0;
                        m_age   <= 1;
                        m_gcid  <= gcid;
                        m_node  <= node;
                        m_split <= split;
                    end
                end
            end else if (m_age < 3) begin
                m_age <= m_age + 1;
                if (m_age == 2) begin
                    m_pkt <= mem[m_idx[CACHE_ADDR_WIDTH-1:0]];
                end
            end else if (ring_bus.i_dirty_feedback && !ring_bus.i_dispatcher_back_pressure) begin
                if (m_idx == m_count - 1) begin
                    m_age  <= 0;
                    m_done <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                    m_age <= 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            checkOutput("rd_en", 64'(ring_bus.o_cache_rd_en), 64'(m_age == 1));
            if (m_age == 1) begin
                checkOutput("rd_addr", 64'(ring_bus.o_cache_rd_addr), 64'(m_idx));
            end
            checkOutput("valid", 64'(ring_bus.o_local_valid),
                        64'((m_age == 3) && !ring_bus.i_dispatcher_back_pressure));
            checkOutput("dirty", 64'(ring_bus.o_local_dirty), 64'(m_age == 3));
            checkOutput("busy", 64'(busy), 64'(m_age != 0));
            checkOutput("done", 64'(done), 64'(m_done));
            checkOutput("pkt", 64'(ring_bus.o_local_offset_pkt), 64'(m_pkt));
            checkOutput("gcid", 64'(ring_bus.o_local_gcid), 64'(m_gcid));
            checkOutput("node_id", 64'(ring_bus.o_local_node_id), 64'(m_node));
            checkOutput("split", 64'(ring_bus.o_local_split_lifetime), 64'(m_split));
        end
    end

    task automatic applyStimulus(input logic s, input int n, input logic [GCID_WIDTH-1:0] g,
                                 input logic [NODE_ID_WIDTH-1:0] nd, input logic [SPLIT_WIDTH-1:0] sp);
        start = s;
        num   = n[PARTICLE_ID_WIDTH-1:0];
        gcid  = g;
        node  = nd;
        split = sp;
    endtask

    task automatic advanceTo(input int k);
        while (cur_cycle < k) begin
            @(posedge clk);
            #1;
            cur_cycle++;
        end
    endtask

    // Start is raised in cycle 0 of a sweep and dropped in cycle 1.
    task automatic startSweep(input int n, input logic [GCID_WIDTH-1:0] g,
                              input logic [NODE_ID_WIDTH-1:0] nd, input logic [SPLIT_WIDTH-1:0] sp);
        applyStimulus(1'b1, n, g, nd, sp);
        cur_cycle = 0;
        advanceTo(1);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            mem[i] = 32'hEE00_0000 | 32'(i);
        end
        mem[0] = 32'hA0A0_0000;
        mem[1] = 32'hB0B0_0001;
        mem[2] = 32'hC0C0_0002;
        mem[3] = 32'hD0D0_0003;
        ring_bus.i_dispatcher_back_pressure = 1'b0;
        ring_bus.i_dirty_feedback           = 1'b0;

        // Reset, then idle.
        cur_cycle = 0;
        advanceTo(3);
        rst = 1'b0;
        advanceTo(6);
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'h0);
        checkOutput("idle_rd_en", 64'(ring_bus.o_cache_rd_en), 64'h0);
        checkOutput("idle_pkt", 64'(ring_bus.o_local_offset_pkt), 64'h0);
        checkOutput("idle_gcid", 64'(ring_bus.o_local_gcid), 64'h0);

        // Three particles with immediate feedback.
        ring_bus.i_dirty_feedback = 1'b1;
        advanceTo(7);
        startSweep(3, 9'h1A3, 3'd5, 12'hABC);
        advanceTo(3);
        @(negedge clk);
        checkOutput("s3_valid_c3", 64'(ring_bus.o_local_valid), 64'h1);
        checkOutput("s3_pkt_a", 64'(ring_bus.o_local_offset_pkt), 64'hA0A0_0000);
        checkOutput("s3_gcid", 64'(ring_bus.o_local_gcid), 64'h1A3);
        checkOutput("s3_split", 64'(ring_bus.o_local_split_lifetime), 64'hABC);
        advanceTo(4);
        @(negedge clk);
        checkOutput("s3_rd_addr1", 64'({ring_bus.o_cache_rd_en, ring_bus.o_cache_rd_addr}), 64'h11);
        advanceTo(6);
        @(negedge clk);
        checkOutput("s3_pkt_b", 64'(ring_bus.o_local_offset_pkt), 64'hB0B0_0001);
        advanceTo(9);
        @(negedge clk);
        checkOutput("s3_pkt_c", 64'(ring_bus.o_local_offset_pkt), 64'hC0C0_0002);
        advanceTo(10);
        @(negedge clk);
        checkOutput("s3_done_c10", 64'(done), 64'h1);
        advanceTo(11);
        @(negedge clk);
        checkOutput("s3_done_once", 64'(done), 64'h0);

        // Back pressure for four PRESENT cycles with feedback held high.
        ring_bus.i_dispatcher_back_pressure = 1'b1;
        startSweep(2, 9'h055, 3'd2, 12'h123);
        advanceTo(5);
        @(negedge clk);
        checkOutput("bp_valid_low", 64'(ring_bus.o_local_valid), 64'h0);
        checkOutput("bp_dirty", 64'(ring_bus.o_local_dirty), 64'h1);
        checkOutput("bp_pkt_held", 64'(ring_bus.o_local_offset_pkt), 64'hA0A0_0000);
        advanceTo(7);
        ring_bus.i_dispatcher_back_pressure = 1'b0;
        @(negedge clk);
        checkOutput("bp_valid_c7", 64'(ring_bus.o_local_valid), 64'h1);
        advanceTo(8);
        @(negedge clk);
        checkOutput("bp_rd_addr1", 64'({ring_bus.o_cache_rd_en, ring_bus.o_cache_rd_addr}), 64'h11);
        advanceTo(11);
        @(negedge clk);
        checkOutput("bp_done_c11", 64'(done), 64'h1);
        advanceTo(13);

        // Empty sweep.
        startSweep(0, 9'h1FF, 3'd7, 12'hFFF);
        @(negedge clk);
        checkOutput("zero_done_c1", 64'(done), 64'h1);
        checkOutput("zero_busy", 64'(busy), 64'h0);
        advanceTo(2);
        @(negedge clk);
        checkOutput("zero_done_once", 64'(done), 64'h0);
        checkOutput("zero_gcid_kept", 64'(ring_bus.o_local_gcid), 64'h055);
        advanceTo(3);

        // Reset while packet 1 of 4 is on offer.
        startSweep(4, 9'h0F0, 3'd3, 12'h456);
        advanceTo(6);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_pkt_b", 64'(ring_bus.o_local_offset_pkt), 64'hB0B0_0001);
        advanceTo(7);
        @(negedge clk);
        checkOutput("rst_pkt_zero", 64'(ring_bus.o_local_offset_pkt), 64'h0);
        checkOutput("rst_dirty_zero", 64'(ring_bus.o_local_dirty), 64'h0);
        checkOutput("rst_gcid_zero", 64'(ring_bus.o_local_gcid), 64'h0);
        checkOutput("rst_done_zero", 64'(done), 64'h0);
        advanceTo(8);
        rst = 1'b0;
        advanceTo(9);
        startSweep(1, 9'h0AA, 3'd1, 12'h789);
        advanceTo(3);
        @(negedge clk);
        checkOutput("post_rst_pkt", 64'(ring_bus.o_local_offset_pkt), 64'hA0A0_0000);
        advanceTo(4);
        @(negedge clk);
        checkOutput("post_rst_done", 64'(done), 64'h1);
        advanceTo(5);

        // Start pulsed mid-sweep must be ignored.
        startSweep(3, 9'h002, 3'd4, 12'h321);
        advanceTo(2);
        applyStimulus(1'b1, 1, 9'h005, 3'd6, 12'h000);
        advanceTo(3);
        start = 1'b0;
        advanceTo(4);
        @(negedge clk);
        checkOutput("ign_gcid", 64'(ring_bus.o_local_gcid), 64'h002);
        advanceTo(9);
        @(negedge clk);
        checkOutput("ign_pkt_c", 64'(ring_bus.o_local_offset_pkt), 64'hC0C0_0002);
        advanceTo(10);
        @(negedge clk);
        checkOutput("ign_done_c10", 64'(done), 64'h1);
        advanceTo(13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
